// File: rtl/stdin_rx_pkg.sv
// Shared types and defaults for the stdin UART receiver path.
// Optional even-parity support is selected with STDIN_RX_PARITY_EN.
package stdin_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } rx_state_t;

  // 115200 baud from a 12 MHz clock
  localparam int BAUD_DEFAULT  = 104;
  localparam int DEPTH_DEFAULT = 16;

  // Even parity: data bits plus parity bit must XOR to zero.
  function automatic logic even_parity_err(input logic [7:0] data, input logic par_bit);
    return (^data) ^ par_bit;
  endfunction

endpackage

// File: rtl/stdin_rx_sync_fifo.sv
// First-word-fall-through synchronous FIFO with pointer-plus-wrap-bit addressing.
// Reusable for buffering stdout ahead of uart_tx as well.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop_ok  = pop && !empty;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign count   = wr_ptr - rd_ptr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stdin_rx.sv
// UART receiver (8N1, or 8E1 when STDIN_RX_PARITY_EN is defined) feeding a
// byte FIFO that supplies the Brainfuck core's ',' instruction.
module stdin_rx
  import stdin_rx_pkg::*;
#(
  parameter int BAUD  = BAUD_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rx,
  input  logic             rd_en,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic [CNT_W-1:0] count,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = $clog2(BAUD);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD - 1);

  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          par_err;
  logic          rx_meta;
  logic          rx_s;
  logic          push;
  logic          fifo_full;
  logic          fifo_empty;

  // Two-flop synchronizer, preset to the idle line level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign push     = (state == S_STOP) && (cnt == '0) && rx_s && !par_err;
  assign rd_valid = !fifo_empty;
  assign busy     = (state != S_IDLE);

  // Receive FSM with mid-bit sampling and registered error pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= 3'd0;
      shreg     <= 8'h00;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= push && fifo_full && !(rd_en && rd_valid);
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state   <= S_START;
            cnt     <= HALF_LOAD;
            par_err <= 1'b0;
          end
        end
        S_START: begin
          if (cnt == '0) begin
            if (!rx_s) begin
              state <= S_DATA;
              cnt   <= FULL_LOAD;
              idx   <= 3'd0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == '0) begin
            shreg[idx] <= rx_s;
            cnt        <= FULL_LOAD;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef STDIN_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_PARITY: begin
          if (cnt == '0) begin
            par_err <= even_parity_err(shreg, rx_s);
            state   <= S_STOP;
            cnt     <= FULL_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == '0) begin
            // A bad stop bit wins over a bad parity bit: one pulse either way.
            if (rx_s) begin
              frame_err <= par_err;
              state     <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_s) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (shreg),
    .pop       (rd_en),
    .rd_data   (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

endmodule
